// File: rtl/jtag_scan_master_pkg.sv
// Shared types and sequence lengths for the JTAG scan master.
// No logic; states and TCK-cycle counts of each scan phase.
package jtag_scan_master_pkg;

    typedef enum logic [3:0] {
        TLR_SEQ,
        IDLE,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE,
        RSP
    } state_t;

    localparam int TLR_CYCLES = 5;
    localparam int DR_PRE     = 3;
    localparam int IR_PRE     = 4;
    localparam int POST       = 2;

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider, CLK_DIV clk_i cycles per half-period, parked low when en=0.
// Latency: rise_stb/fall_stb flag the clk_i edge that will toggle tck.
// Backpressure: none; dropping en stops TCK and restarts the half-period.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] cnt;
    logic          toggle;

    assign toggle   = en && (cnt == DW'(CLK_DIV - 1));
    assign rise_stb = toggle && !tck;
    assign fall_stb = toggle && tck;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (toggle) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: IR/DR scan initiator on TCK/TMS/TDI/TDO; JTAG_SCAN_MASTER_TRST_EN adds trst_no/cmd_trst_i.
// Latency: (len+5)*2*CLK_DIV+1 clk_i for DR, (len+6)*2*CLK_DIV+1 for IR, 1 for len=0.
// Backpressure: one command in flight; cmd_ready_o stays low until rsp_valid_o is accepted.
module jtag_scan_master
    import jtag_scan_master_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_ir_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len_i,
    input  logic [MAX_LEN-1:0]           cmd_tdi_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [MAX_LEN-1:0]           rsp_tdo_o,
    output logic                         tck_o,
    output logic                         tms_o,
    output logic                         tdi_o,
`ifdef JTAG_SCAN_MASTER_TRST_EN
    input  logic                         cmd_trst_i,
    output logic                         trst_no,
`endif
    input  logic                         tdo_i
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam int CW = (LW > 3) ? LW : 3;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [LW-1:0]        len_q, len_sat;
    logic                 ir_q;
    logic [MAX_LEN-1:0]   tdi_q, tdo_q;
    logic                 rsp_vld_q;
    logic                 tck_en, rise_stb, fall_stb;
    logic                 accept, rsp_done, cnt_last;
    logic                 cmd_trst, trst_cmd;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en       (tck_en),
        .tck      (tck_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    assign accept   = cmd_valid_i && (state == IDLE);
    assign rsp_done = rsp_vld_q && rsp_ready_i;
    assign len_sat  = (cmd_len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len_i;
    assign bit_idx  = cnt[IW-1:0];

    // Last TCK cycle of a multi-cycle phase; the second CAPTURE cycle is the capture edge.
    always_comb begin
        cnt_last = 1'b0;
        case (state)
            TLR_SEQ: cnt_last = (cnt == CW'(TLR_CYCLES));
            CAPTURE: cnt_last = (cnt == CW'(DR_PRE - 2));
            SHIFT:   cnt_last = (cnt == CW'(len_q - LW'(1)));
            default: cnt_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= TLR_SEQ;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR_SEQ: if (fall_stb && cnt_last) state_nxt = trst_cmd ? RSP : IDLE;
            IDLE: if (cmd_valid_i) begin
                if (cmd_trst)            state_nxt = TLR_SEQ;
                else if (len_sat == '0)  state_nxt = RSP;
                else                     state_nxt = SEL_DR;
            end
            SEL_DR:  if (fall_stb) state_nxt = ir_q ? SEL_IR : CAPTURE;
            SEL_IR:  if (fall_stb) state_nxt = CAPTURE;
            CAPTURE: if (fall_stb && cnt_last) state_nxt = SHIFT;
            SHIFT:   if (fall_stb && cnt_last) state_nxt = EXIT1;
            EXIT1:   if (fall_stb) state_nxt = UPDATE;
            UPDATE:  if (fall_stb) state_nxt = RSP;
            RSP:     if (rsp_done) state_nxt = IDLE;
            default: state_nxt = TLR_SEQ;
        endcase
    end

    always_comb begin
        tms_o       = 1'b0;
        tdi_o       = 1'b0;
        cmd_ready_o = (state == IDLE);
        tck_en      = !(state inside {IDLE, RSP});
        case (state)
            TLR_SEQ:               tms_o = (cnt < CW'(TLR_CYCLES));
            SEL_DR, SEL_IR, EXIT1: tms_o = 1'b1;
            SHIFT: begin
                tms_o = cnt_last;
                tdi_o = tdi_q[bit_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            len_q <= '0;
            ir_q  <= 1'b0;
            tdi_q <= '0;
            tdo_q <= '0;
        end else begin
            if (accept) begin
                cnt   <= '0;
                len_q <= len_sat;
                ir_q  <= cmd_ir_i;
                tdi_q <= cmd_tdi_i;
                tdo_q <= '0;
            end else if (fall_stb) begin
                cnt <= (state_nxt != state) ? '0 : cnt + CW'(1);
            end
            if (rise_stb && state == SHIFT) tdo_q[bit_idx] <= tdo_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        rsp_vld_q <= 1'b0;
        else if (state == RSP && !rsp_vld_q) rsp_vld_q <= 1'b1;
        else if (rsp_done)                  rsp_vld_q <= 1'b0;
    end

    assign rsp_valid_o = rsp_vld_q;
    assign rsp_tdo_o   = tdo_q;

`ifdef JTAG_SCAN_MASTER_TRST_EN
    logic trst_q;

    // TRST stays low through the whole TMS reset walk and lifts on its final falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trst_cmd <= 1'b0;
            trst_q   <= 1'b0;
        end else if (accept) begin
            trst_cmd <= cmd_trst_i;
            if (cmd_trst_i) trst_q <= 1'b0;
        end else if (state == TLR_SEQ && fall_stb && cnt_last) begin
            trst_q <= 1'b1;
        end
    end

    assign cmd_trst = cmd_trst_i;
    assign trst_no  = trst_q;
`else
    assign cmd_trst = 1'b0;
    assign trst_cmd = 1'b0;
`endif

endmodule
